usr_shift_sequencer: RTL and testbench
======================================

Name: usr_shift_sequencer

Overview:
Sequencer that owns one WIDTH-bit universal shift register and runs it as a serial transmit/capture engine. It accepts a parallel word on a valid/ready handshake and loads it into the register. It then shifts the word out serially in the selected direction while shifting ser_in in, one shift per DIV clock cycles. When the frame completes, it presents the captured word on a valid/ready output. It sits between a parallel host interface and a bit-serial link.

Parameters:
WIDTH, 4, shift register width and number of shifts per frame (>=2)
DIV, 1, clocks per shift (>=1); divider width is clog2(DIV) with a minimum of 1
CNT_W, clog2(WIDTH+1), bit-counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
start_valid  in  1  host offers a frame
start_ready  out  1  sequencer can accept a frame
tx_data  in  WIDTH  parallel word to send, captured on handshake
dir  in  1  shift direction, captured on handshake: 0 = right (ser_in enters MSB, ser_out = Q[0]); 1 = left (ser_in enters LSB, ser_out = Q[WIDTH-1])
hold  in  1  pauses shifting while high
abort  in  1  synchronous frame abort
ser_in  in  1  serial input bit
ser_out  out  1  serial output bit
rx_valid  out  1  captured word available
rx_data  out  WIDTH  captured word (equals Q)
rx_ready  in  1  consumer accepts rx_data
busy  out  1  high in SHIFT or DONE

Behaviour:
- Reset (asynchronous): state=IDLE; Q=0; divider=0; bit counter=0; dir_r=0; start_ready=1; rx_valid=0; busy=0; ser_out=0.
- States are IDLE, SHIFT and DONE. The datapath mode is decoded from the state: 00 hold, 01 right, 10 left, 11 load.
- IDLE:
  - start_ready=1 unless abort=1.
  - On start_valid&&start_ready at edge E0: Q<=tx_data; dir_r<=dir; divider<=0; count<=0; go to SHIFT.
  - With no handshake, Q holds.
- SHIFT:
  - The divider counts 0..DIV-1. When the divider reaches DIV-1 and hold=0, a shift tick occurs: one shift in direction dir_r with ser_in sampled on that edge, count increments, and the divider clears.
  - Shift k (k=1..WIDTH) lands on edge E0+k*DIV when hold is never asserted.
  - hold=1 freezes the divider, the counter and Q (mode 00).
  - After the WIDTH-th shift, go to DONE. rx_valid is high in the cycle after edge E0+WIDTH*DIV.
- ser_out is combinational from Q[0] (dir_r=0) or Q[WIDTH-1] (dir_r=1) in all states. Each bit is stable for the whole DIV period before its shift.
- DONE:
  - rx_valid=1 and rx_data=Q, both held stable until rx_ready=1.
  - On rx_valid&&rx_ready: go to IDLE. start_ready rises the following cycle; there is no same-cycle turnaround.
- abort=1 in SHIFT or DONE: go to IDLE next edge; Q holds; rx_valid drops without a handshake. abort in IDLE blocks acceptance.
- Priority, highest first: reset > abort > hold > shift tick.
- busy=1 in SHIFT and DONE.
- Q is never written outside the load and shift cases.
- Reset during an active frame returns to the reset values immediately. No partial rx_valid is produced.

Decomposition:
- Shared package usr_pkg:
  - mode encoding constants USR_HOLD=2'b00, USR_SHR=2'b01, USR_SHL=2'b10, USR_LOAD=2'b11
  - state enum seq_state_t {IDLE, SHIFT, DONE}
- One sub-module, usr_datapath (parameter WIDTH): clk, reset, mode, parallel_in, serial_in_left, serial_in_right, Q, with the same four-mode behaviour.
- The sequencer holds only the FSM, the divider, the bit counter, dir_r and output decode.

Test Plan:
1. WIDTH=4, DIV=1, load 1010, dir=0, ser_in=1 -> ser_out 0,1,0,1 on successive cycles; Q 1101,1110,1111,1111; rx_valid 1 cycle after 4th shift; rx_data=1111.
2. Load 1010, dir=1, ser_in=0 -> ser_out 1,0,1,0; rx_data=0000.
3. Loopback ser_in=ser_out, dir=0, load 0110, DIV=3 -> each ser_out bit stable 3 cycles; shifts at E0+3,6,9,12; rx_data=0110.
4. Load 1010, hold=1 for 5 cycles after the 2nd shift, rx_ready=0 for 4 cycles in DONE -> Q frozen at 1110 during hold; rx_data stable at 1111 until the handshake; start_ready=0 throughout; start_ready=1 the cycle after the handshake.
5. abort after the 2nd shift -> IDLE next edge; Q=1110 holds; rx_valid never asserted; a new frame is accepted normally.
6. reset mid-SHIFT and mid-DONE -> Q=0000, rx_valid=0, start_ready=1 asynchronously. Separately, abort with start_valid in IDLE -> start_ready=0 and no load.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register and its sequencer:
// datapath mode encodings, sequencer states and a divider-width helper.
package usr_pkg;

    // Datapath operation selected each cycle by the sequencer
    localparam logic [1:0] USR_HOLD = 2'b00;
    localparam logic [1:0] USR_SHR  = 2'b01;
    localparam logic [1:0] USR_SHL  = 2'b10;
    localparam logic [1:0] USR_LOAD = 2'b11;

    // Frame sequencing states
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } seq_state_t;

    // Width of a counter that runs 0..div-1, never narrower than one bit
    function automatic int div_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/usr_datapath.sv
// Universal shift register: hold, shift right, shift left or parallel load,
// chosen by a two-bit mode. A right shift takes its new MSB from
// serial_in_right; a left shift takes its new LSB from serial_in_left.
module usr_datapath
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             serial_in_left,
    input  logic             serial_in_right,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next register value; anything other than shift/load keeps the contents
    always_comb begin
        q_d = q_q;
        case (mode)
            USR_SHR:  q_d = {serial_in_right, q_q[WIDTH-1:1]};
            USR_SHL:  q_d = {q_q[WIDTH-2:0], serial_in_left};
            USR_LOAD: q_d = parallel_in;
            default:  q_d = q_q;
        endcase
    end

    // Register storage, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/usr_shift_sequencer.sv
// Serial transmit/capture engine around a universal shift register.
// A parallel word is accepted on start_valid/start_ready, shifted out on
// ser_out while ser_in is shifted in (one shift per DIV clocks), and the
// captured word is presented on rx_valid/rx_data until rx_ready.
module usr_shift_sequencer
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             dir,
    input  logic             hold,
    input  logic             abort,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    input  logic             rx_ready,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int DIV_W = div_width(DIV);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);

    seq_state_t       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [1:0]       mode;
    logic [WIDTH-1:0] q;

    usr_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk             (clk),
        .reset           (reset),
        .mode            (mode),
        .parallel_in     (tx_data),
        .serial_in_left  (ser_in),
        .serial_in_right (ser_in),
        .Q               (q)
    );

    assign start_ready = (state_q == IDLE) && !abort;
    assign busy        = (state_q != IDLE);
    assign rx_valid    = (state_q == DONE);
    assign rx_data     = q;
    assign ser_out     = dir_q ? q[WIDTH-1] : q[0];

    // Next-state, divider/counter update and datapath mode; abort beats hold beats tick
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        mode    = USR_HOLD;
        case (state_q)
            IDLE: begin
                if (start_valid && start_ready) begin
                    mode    = USR_LOAD;
                    dir_d   = dir;
                    div_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (!hold) begin
                    if (div_q == DIV_LAST) begin
                        mode  = dir_q ? USR_SHL : USR_SHR;
                        div_d = '0;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_d = DONE;
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
            end
            DONE: begin
                if (abort || rx_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer registers, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Self-checking bench for usr_shift_sequencer: directed frames plus
// randomized traffic, compared every cycle against a word-level model.
module tb_usr_shift_sequencer;

    localparam int WIDTH = 4;
    localparam int DIV   = 3;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic             clk;
    logic             reset;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] tx_data;
    logic             dir;
    logic             hold;
    logic             abort;
    logic             ser_in;
    logic             ser_out;
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic             rx_ready;
    logic             busy;

    int check_count = 0;
    int pass_count  = 0;

    // Reference model: frame in progress, word, direction, shifts done, clocks since last shift
    bit m_active;
    int m_word;
    bit m_dir;
    int m_shifts;
    int m_elapsed;

    usr_shift_sequencer #(
        .WIDTH(WIDTH),
        .DIV  (DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .tx_data     (tx_data),
        .dir         (dir),
        .hold        (hold),
        .abort       (abort),
        .ser_in      (ser_in),
        .ser_out     (ser_out),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .busy        (busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_ser_out();
        return m_dir ? 1'(m_word >> (WIDTH - 1)) : 1'(m_word);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Advance the model by one rising edge with the given inputs
    task automatic modelStep(input logic sv, input logic [WIDTH-1:0] td, input logic d,
                             input logic h, input logic ab, input logic si, input logic rr);
        if (!m_active) begin
            if (sv && !ab) begin
                m_word    = int'(td);
                m_dir     = d;
                m_shifts  = 0;
                m_elapsed = 0;
                m_active  = 1'b1;
            end
        end else if (ab) begin
            m_active = 1'b0;
        end else if (m_shifts == WIDTH) begin
            if (rr) m_active = 1'b0;
        end else if (!h) begin
            m_elapsed++;
            if (m_elapsed == DIV) begin
                if (m_dir) m_word = ((m_word << 1) | int'(si)) & MASK;
                else       m_word = (m_word >> 1) | (int'(si) << (WIDTH - 1));
                m_shifts++;
                m_elapsed = 0;
            end
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then step the model
    task automatic applyStimulus(input logic sv, input logic [WIDTH-1:0] td, input logic d,
                                 input logic h, input logic ab, input logic si, input logic rr);
        start_valid = sv;
        tx_data     = td;
        dir         = d;
        hold        = h;
        abort       = ab;
        ser_in      = si;
        rx_ready    = rr;
        @(negedge clk);
        checkOutput("start_ready", 32'(start_ready), 32'(!m_active && !ab));
        checkOutput("busy",        32'(busy),        32'(m_active));
        checkOutput("rx_valid",    32'(rx_valid),    32'(m_active && (m_shifts == WIDTH)));
        checkOutput("rx_data",     32'(rx_data),     32'(m_word));
        checkOutput("ser_out",     32'(ser_out),     32'(model_ser_out()));
        @(posedge clk);
        modelStep(sv, td, d, h, ab, si, rr);
        #1;
    endtask

    // Assert reset between edges and check the asynchronous response
    task automatic doReset();
        start_valid = 1'b0;
        tx_data     = '0;
        dir         = 1'b0;
        hold        = 1'b0;
        abort       = 1'b0;
        ser_in      = 1'b0;
        rx_ready    = 1'b0;
        reset       = 1'b1;
        #1;
        m_active  = 1'b0;
        m_word    = 0;
        m_dir     = 1'b0;
        m_shifts  = 0;
        m_elapsed = 0;
        checkOutput("rst_start_ready", 32'(start_ready), 32'd1);
        checkOutput("rst_busy",        32'(busy),        32'd0);
        checkOutput("rst_rx_valid",    32'(rx_valid),    32'd0);
        checkOutput("rst_rx_data",     32'(rx_data),     32'd0);
        checkOutput("rst_ser_out",     32'(ser_out),     32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        modelStep(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        doReset();

        // Right shift of 1010 with ser_in=1
        applyStimulus(1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < WIDTH * DIV; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t1_rx_valid", 32'(rx_valid), 32'd1);
        checkOutput("t1_rx_data",  32'(rx_data),  32'b1111);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t1_start_ready", 32'(start_ready), 32'd1);

        // Left shift of 1010 with ser_in=0
        applyStimulus(1'b1, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH * DIV; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_rx_data", 32'(rx_data), 32'b0000);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Loopback: ser_in follows ser_out, word returns unchanged
        applyStimulus(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH * DIV; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, model_ser_out(), 1'b0);
        checkOutput("t3_rx_data", 32'(rx_data), 32'b0110);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Hold after two shifts, then delayed consumer
        applyStimulus(1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2 * DIV; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("t4_hold_q",     32'(rx_data),     32'b1110);
        checkOutput("t4_hold_ready", 32'(start_ready), 32'd0);
        for (int i = 0; i < 2 * DIV; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t4_rx_valid", 32'(rx_valid), 32'd1);
        checkOutput("t4_rx_data",  32'(rx_data),  32'b1111);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t4_start_ready", 32'(start_ready), 32'd1);

        // Abort after two shifts, then a fresh frame
        applyStimulus(1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2 * DIV; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("t5_busy",     32'(busy),     32'd0);
        checkOutput("t5_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("t5_q",        32'(rx_data),  32'b1110);
        applyStimulus(1'b1, 4'b0011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < WIDTH * DIV; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t5_rx_data", 32'(rx_data), 32'b1111);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-SHIFT, reset mid-DONE, abort blocking acceptance in IDLE
        applyStimulus(1'b1, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        doReset();
        applyStimulus(1'b1, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < WIDTH * DIV + 1; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        doReset();
        applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("t6_no_load_busy", 32'(busy),    32'd0);
        checkOutput("t6_no_load_q",    32'(rx_data), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                doReset();
            end else begin
                applyStimulus(1'($urandom_range(0, 9) < 3),
                              WIDTH'($urandom),
                              1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 9) == 0),
                              1'($urandom_range(0, 39) == 0),
                              1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)));
            end
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
